// File: rtl/pnode_channel_filter_pkg.sv
// Shared field positions, FSM state type and output word layout for the
// per-node channel filter.
package pnode_pkg;

    localparam int CH_HI   = 137;
    localparam int CH_LO   = 130;
    localparam int SOP_BIT = 129;
    localparam int EOP_BIT = 128;
    localparam int DATA_W  = 128;
    localparam int TAP_W   = 138;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } pnode_state_t;

    typedef struct packed {
        logic              err;
        logic [7:0]        channel;
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } pnode_word_t;

    // Saturating 32-bit increment: statistics stick at all-ones.
    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pnode_channel_filter_out_fifo.sv
// First-word-fall-through output FIFO with occupancy count. A push into a
// full FIFO is only honoured when a pop frees a slot in the same cycle.
module pnode_out_fifo #(
    parameter  int WIDTH = 139,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             aclr_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pushData,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_popData,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_popData = r_mem[r_rdPtr];
    assign w_doPop   = i_pop && !o_empty;
    assign w_doPush  = i_push && (!o_full || w_doPop);

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clock) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
            if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pnode_channel_filter.sv
// Per-node tap consumer: requests words from the input chain, keeps the
// packets addressed to this node, and re-emits them through a small FIFO
// whose free space is reserved before each request is issued.
module pnode_channel_filter
    import pnode_pkg::*;
#(
    parameter logic [7:0] NODE_ID   = 8'd0,
    parameter logic       MATCH_ALL = 1'b0,
    parameter int         DEPTH     = 4
) (
    input  logic               clock,
    input  logic               aclr_n,
    input  logic [TAP_W-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_sop,
    output logic               out_eop,
    output logic               out_err,
    output logic [7:0]         out_channel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        stat_pkts,
    output logic [31:0]        stat_drops,
    output logic [31:0]        stat_errs
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    pnode_state_t r_state;
    logic [7:0]   r_channel;
    logic         r_pending;
    logic         r_alive;
    logic [31:0]  r_statPkts;
    logic [31:0]  r_statDrops;
    logic [31:0]  r_statErrs;

    pnode_state_t     w_next;
    pnode_word_t      w_pushWord;
    pnode_word_t      w_popWord;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_credit;
    logic             w_accept;
    logic             w_match;
    logic             w_latch;
    logic             w_incPkt;
    logic             w_incDrop;
    logic             w_incErr;
    logic [7:0]       w_inCh;
    logic             w_inSop;
    logic             w_inEop;

    assign w_inCh   = in_data[CH_HI:CH_LO];
    assign w_inSop  = in_data[SOP_BIT];
    assign w_inEop  = in_data[EOP_BIT];
    assign w_match  = MATCH_ALL || (w_inCh == NODE_ID);

    // Outstanding requests plus stored words must stay below DEPTH, using the
    // count before any same-cycle pop so every answered request has a slot.
    assign w_credit = {1'b0, w_count} + {{CNT_W{1'b0}}, r_pending};
    assign in_ready = r_alive && (w_credit < (CNT_W + 1)'(DEPTH));

    // Requested words always fit; an unrequested word needs a free slot.
    assign w_accept = in_valid && (r_pending || !w_full);

    assign w_pop       = !w_empty && out_ready;
    assign out_valid   = !w_empty;
    assign out_data    = w_popWord.data;
    assign out_sop     = w_popWord.sop;
    assign out_eop     = w_popWord.eop;
    assign out_err     = w_popWord.err;
    assign out_channel = w_popWord.channel;
    assign stat_pkts   = r_statPkts;
    assign stat_drops  = r_statDrops;
    assign stat_errs   = r_statErrs;

    // Packet framing: decide what to push, where to go and what to count.
    always_comb begin
        w_next             = r_state;
        w_push             = 1'b0;
        w_latch            = 1'b0;
        w_incPkt           = 1'b0;
        w_incDrop          = 1'b0;
        w_incErr           = 1'b0;
        w_pushWord.err     = 1'b0;
        w_pushWord.channel = r_channel;
        w_pushWord.sop     = w_inSop;
        w_pushWord.eop     = w_inEop;
        w_pushWord.data    = in_data[DATA_W-1:0];
        if (in_valid && !w_accept) begin
            w_incErr = 1'b1;
        end else if (w_accept) begin
            if (r_state == PASS) begin
                w_push = 1'b1;
                if (!w_inSop) begin
                    if (w_inEop) begin
                        w_incPkt = 1'b1;
                        w_next   = IDLE;
                    end
                end else begin
                    w_pushWord.sop  = 1'b0;
                    w_pushWord.eop  = 1'b1;
                    w_pushWord.err  = 1'b1;
                    w_pushWord.data = '0;
                    w_incErr        = 1'b1;
                    w_next          = w_inEop ? IDLE : DROP;
                end
            end else if ((r_state == DROP) && !w_inSop) begin
                if (w_inEop) w_next = IDLE;
            end else begin
                if ((r_state == DROP) || !w_inSop) w_incErr = 1'b1;
                if (w_inSop) begin
                    w_latch = 1'b1;
                    if (w_match) begin
                        w_push             = 1'b1;
                        w_pushWord.channel = w_inCh;
                        if (w_inEop) w_incPkt = 1'b1;
                        else         w_next   = PASS;
                    end else begin
                        w_incDrop = 1'b1;
                        w_next    = w_inEop ? IDLE : DROP;
                    end
                end
            end
        end
    end

    // FSM state, latched channel, request tracking and statistics.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_state     <= IDLE;
            r_channel   <= '0;
            r_pending   <= 1'b0;
            r_alive     <= 1'b0;
            r_statPkts  <= '0;
            r_statDrops <= '0;
            r_statErrs  <= '0;
        end else begin
            r_state   <= w_next;
            r_pending <= in_ready;
            r_alive   <= 1'b1;
            if (w_latch)   r_channel   <= w_inCh;
            if (w_incPkt)  r_statPkts  <= satInc(r_statPkts);
            if (w_incDrop) r_statDrops <= satInc(r_statDrops);
            if (w_incErr)  r_statErrs  <= satInc(r_statErrs);
        end
    end

    pnode_out_fifo #(
        .WIDTH ($bits(pnode_word_t)),
        .DEPTH (DEPTH)
    ) u_outFifo (
        .clock      (clock),
        .aclr_n     (aclr_n),
        .i_push     (w_push),
        .i_pushData (w_pushWord),
        .i_pop      (w_pop),
        .o_popData  (w_popWord),
        .o_count    (w_count),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

endmodule

// File: tb/tb_pnode_channel_filter.sv
// Directed bench for pnode_channel_filter with NODE_ID=3, DEPTH=4.
module tb_pnode_channel_filter;
    import pnode_pkg::*;

    logic         clock = 1'b0;
    logic         aclr_n;
    logic [137:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_sop;
    logic         out_eop;
    logic         out_err;
    logic [7:0]   out_channel;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  stat_pkts;
    logic [31:0]  stat_drops;
    logic [31:0]  stat_errs;

    int           testCount = 0;
    int           failCount = 0;
    int           cyc = 0;
    int           firstDriveCyc;
    bit           sendDone;
    logic [137:0] stim[$];
    pnode_word_t  outQ[$];
    int           popCyc[$];
    pnode_word_t  monWord;

    pnode_channel_filter #(
        .NODE_ID   (8'd3),
        .MATCH_ALL (1'b0),
        .DEPTH     (4)
    ) dut (
        .clock       (clock),
        .aclr_n      (aclr_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_err     (out_err),
        .out_channel (out_channel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .stat_pkts   (stat_pkts),
        .stat_drops  (stat_drops),
        .stat_errs   (stat_errs)
    );

    // Free-running clock and cycle counter.
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Capture every accepted output word with the cycle it was taken.
    always @(negedge clock) begin
        if (aclr_n && out_valid && out_ready) begin
            monWord.err     = out_err;
            monWord.channel = out_channel;
            monWord.sop     = out_sop;
            monWord.eop     = out_eop;
            monWord.data    = out_data;
            outQ.push_back(monWord);
            popCyc.push_back(cyc);
        end
    end

    // Hard stop in case something never settles.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [137:0] mkTap(input logic [7:0] ch, input logic sop,
                                           input logic eop, input logic [127:0] d);
        return {ch, sop, eop, d};
    endfunction

    function automatic pnode_word_t mkOut(input logic err, input logic [7:0] ch,
                                          input logic sop, input logic eop,
                                          input logic [127:0] d);
        pnode_word_t w;
        w.err = err; w.channel = ch; w.sop = sop; w.eop = eop; w.data = d;
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [159:0] obs,
                               input logic [159:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tap model: answer each request with the next queued word one cycle later.
    task automatic applyStimulus();
        int guard;
        bit req;
        guard = 0;
        firstDriveCyc = -1;
        while (stim.size() > 0 && guard < 300) begin
            @(negedge clock);
            req = in_ready;
            @(posedge clock);
            #1;
            if (req) begin
                in_valid = 1'b1;
                in_data  = stim.pop_front();
                if (firstDriveCyc < 0) firstDriveCyc = cyc;
            end else begin
                in_valid = 1'b0;
            end
            guard++;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        checkOutput("sendBudget", 160'(stim.size()), 160'(0));
        stim.delete();
        sendDone = 1'b1;
    endtask

    task automatic doReset();
        aclr_n   = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rstInReady",  160'(in_ready),   160'(0));
        checkOutput("rstOutValid", 160'(out_valid),  160'(0));
        checkOutput("rstPkts",     160'(stat_pkts),  160'(0));
        checkOutput("rstDrops",    160'(stat_drops), 160'(0));
        checkOutput("rstErrs",     160'(stat_errs),  160'(0));
        @(negedge clock);
        aclr_n = 1'b1;
        outQ.delete();
        popCyc.delete();
        @(posedge clock);
        #1;
        checkOutput("postRstReady", 160'(in_ready), 160'(1));
    endtask

    initial begin
        aclr_n    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Credit stall: four words fill the FIFO, then requests stop.
        doReset();
        for (int i = 0; i < 4; i++) stim.push_back(mkTap(8'd3, 1'b1, 1'b1, 128'hA0 + 128'(i)));
        applyStimulus();
        repeat (3) @(posedge clock);
        #1;
        checkOutput("stallReady", 160'(in_ready),  160'(0));
        checkOutput("stallValid", 160'(out_valid), 160'(1));
        checkOutput("stallPkts",  160'(stat_pkts), 160'(4));
        // Unrequested word while full is discarded as a protocol error.
        in_valid = 1'b1;
        in_data  = mkTap(8'd3, 1'b1, 1'b1, 128'hBAD);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        checkOutput("rogueErrs", 160'(stat_errs), 160'(1));
        checkOutput("roguePkts", 160'(stat_pkts), 160'(4));
        out_ready = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        checkOutput("drainSize", 160'(outQ.size()), 160'(4));
        for (int i = 0; i < 4; i++)
            if (i < outQ.size())
                checkOutput("drainWord", 160'(outQ[i]), 160'(mkOut(1'b0, 8'd3, 1'b1, 1'b1, 128'hA0 + 128'(i))));
        checkOutput("drainReady", 160'(in_ready), 160'(1));

        // Three-word packet; continuation words carry a bogus channel field.
        doReset();
        stim.push_back(mkTap(8'd3,  1'b1, 1'b0, 128'h100));
        stim.push_back(mkTap(8'h77, 1'b0, 1'b0, 128'h101));
        stim.push_back(mkTap(8'h77, 1'b0, 1'b1, 128'h102));
        applyStimulus();
        repeat (6) @(posedge clock);
        #1;
        checkOutput("p3Size", 160'(outQ.size()), 160'(3));
        if (outQ.size() == 3) begin
            checkOutput("p3W0", 160'(outQ[0]), 160'(mkOut(1'b0, 8'd3, 1'b1, 1'b0, 128'h100)));
            checkOutput("p3W1", 160'(outQ[1]), 160'(mkOut(1'b0, 8'd3, 1'b0, 1'b0, 128'h101)));
            checkOutput("p3W2", 160'(outQ[2]), 160'(mkOut(1'b0, 8'd3, 1'b0, 1'b1, 128'h102)));
            checkOutput("p3Latency", 160'(popCyc[0] - firstDriveCyc), 160'(1));
            checkOutput("p3Run1",    160'(popCyc[1] - popCyc[0]),     160'(1));
            checkOutput("p3Run2",    160'(popCyc[2] - popCyc[0]),     160'(2));
        end
        checkOutput("p3Pkts", 160'(stat_pkts), 160'(1));

        // Foreign packet dropped, following single-word packet kept.
        doReset();
        stim.push_back(mkTap(8'd5, 1'b1, 1'b0, 128'h1));
        stim.push_back(mkTap(8'd5, 1'b0, 1'b1, 128'h2));
        stim.push_back(mkTap(8'd3, 1'b1, 1'b1, 128'h3));
        applyStimulus();
        repeat (6) @(posedge clock);
        #1;
        checkOutput("dropSize", 160'(outQ.size()), 160'(1));
        if (outQ.size() == 1)
            checkOutput("dropWord", 160'(outQ[0]), 160'(mkOut(1'b0, 8'd3, 1'b1, 1'b1, 128'h3)));
        checkOutput("dropDrops", 160'(stat_drops), 160'(1));
        checkOutput("dropPkts",  160'(stat_pkts),  160'(1));
        checkOutput("dropErrs",  160'(stat_errs),  160'(0));

        // Unexpected sop mid-packet produces a terminator; new packet dropped.
        doReset();
        stim.push_back(mkTap(8'd3, 1'b1, 1'b0, 128'h11));
        stim.push_back(mkTap(8'd3, 1'b0, 1'b0, 128'h22));
        stim.push_back(mkTap(8'd3, 1'b1, 1'b0, 128'h33));
        stim.push_back(mkTap(8'd3, 1'b0, 1'b1, 128'h44));
        applyStimulus();
        repeat (6) @(posedge clock);
        #1;
        checkOutput("termSize", 160'(outQ.size()), 160'(3));
        if (outQ.size() == 3) begin
            checkOutput("termW0", 160'(outQ[0]), 160'(mkOut(1'b0, 8'd3, 1'b1, 1'b0, 128'h11)));
            checkOutput("termW1", 160'(outQ[1]), 160'(mkOut(1'b0, 8'd3, 1'b0, 1'b0, 128'h22)));
            checkOutput("termW2", 160'(outQ[2]), 160'(mkOut(1'b1, 8'd3, 1'b0, 1'b1, 128'h0)));
        end
        checkOutput("termErrs", 160'(stat_errs), 160'(1));
        checkOutput("termPkts", 160'(stat_pkts), 160'(0));
        stim.push_back(mkTap(8'd3, 1'b1, 1'b1, 128'h55));
        applyStimulus();
        repeat (4) @(posedge clock);
        #1;
        checkOutput("termAfterSize", 160'(outQ.size()), 160'(4));
        if (outQ.size() == 4)
            checkOutput("termAfterWord", 160'(outQ[3]), 160'(mkOut(1'b0, 8'd3, 1'b1, 1'b1, 128'h55)));

        // Orphan continuation word, then a 10-word packet under toggling ready.
        doReset();
        stim.push_back(mkTap(8'd3, 1'b0, 1'b0, 128'hEE));
        applyStimulus();
        repeat (4) @(posedge clock);
        #1;
        checkOutput("orphanSize", 160'(outQ.size()), 160'(0));
        checkOutput("orphanErrs", 160'(stat_errs),   160'(1));
        for (int i = 0; i < 10; i++)
            stim.push_back(mkTap(8'd3, (i == 0), (i == 9), 128'h200 + 128'(i)));
        sendDone = 1'b0;
        fork
            applyStimulus();
            for (int g = 0; g < 400 && !sendDone; g++) begin
                @(posedge clock);
                #1;
                out_ready = ~out_ready;
            end
        join
        out_ready = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        checkOutput("toggleSize", 160'(outQ.size()), 160'(10));
        for (int i = 0; i < 10; i++)
            if (i < outQ.size())
                checkOutput("toggleWord", 160'(outQ[i]),
                            160'(mkOut(1'b0, 8'd3, (i == 0), (i == 9), 128'h200 + 128'(i))));
        checkOutput("togglePkts",  160'(stat_pkts),  160'(1));
        checkOutput("toggleErrs",  160'(stat_errs),  160'(1));
        checkOutput("toggleDrops", 160'(stat_drops), 160'(0));

        // Reset in the middle of a packet leaves no trace.
        doReset();
        stim.push_back(mkTap(8'd3, 1'b1, 1'b0, 128'h66));
        applyStimulus();
        doReset();
        stim.push_back(mkTap(8'd3, 1'b1, 1'b1, 128'h67));
        applyStimulus();
        repeat (4) @(posedge clock);
        #1;
        checkOutput("midRstSize", 160'(outQ.size()), 160'(1));
        if (outQ.size() == 1)
            checkOutput("midRstWord", 160'(outQ[0]), 160'(mkOut(1'b0, 8'd3, 1'b1, 1'b1, 128'h67)));
        checkOutput("midRstPkts", 160'(stat_pkts), 160'(1));
        checkOutput("midRstErrs", 160'(stat_errs), 160'(0));

        // Packet counter saturates at all-ones.
        doReset();
        force dut.r_statPkts = 32'hFFFF_FFFE;
        #1;
        release dut.r_statPkts;
        #1;
        checkOutput("satPreload", 160'(stat_pkts), 160'(32'hFFFF_FFFE));
        stim.push_back(mkTap(8'd3, 1'b1, 1'b1, 128'h1));
        applyStimulus();
        #1;
        checkOutput("satFirst", 160'(stat_pkts), 160'(32'hFFFF_FFFF));
        stim.push_back(mkTap(8'd3, 1'b1, 1'b1, 128'h2));
        stim.push_back(mkTap(8'd3, 1'b1, 1'b1, 128'h3));
        applyStimulus();
        repeat (2) @(posedge clock);
        #1;
        checkOutput("satHold", 160'(stat_pkts), 160'(32'hFFFF_FFFF));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/pnode_channel_filter.md
Name: pnode_channel_filter

Overview:
- Per-node consumer at each tap of the input FIFO chain.
- Consumes the 138-bit tap word {channel[7:0], sop, eop, data[127:0]} using a read-request/next-cycle-valid handshake.
- Keeps packets whose channel matches this node's ID and discards all others.
- Re-emits kept packets as a ready/valid stream through a small credit-protected output FIFO, and keeps packet, drop and framing-error statistics.

Parameters:
- NODE_ID, 8'd0: channel value this node accepts.
- MATCH_ALL, 1'b0: when 1, accept every channel and ignore NODE_ID.
- DEPTH, 4: output FIFO entries. Minimum 2. 3 or more is needed for 1 word/cycle.

Ports:
- clock, in, 1: sole clock; all logic is on the rising edge.
- aclr_n, in, 1: reset, asynchronous assert, active-low.
- in_data, in, 138: tap word; [137:130] channel, [129] sop, [128] eop, [127:0] data.
- in_valid, in, 1: tap word valid; arrives one cycle after in_ready.
- in_ready, out, 1: read request to the tap.
- out_data, out, 128: payload.
- out_sop, out, 1: start of packet.
- out_eop, out, 1: end of packet.
- out_err, out, 1: marks a truncated-packet terminator word.
- out_channel, out, 8: channel of the packet.
- out_valid, out, 1: output word valid.
- out_ready, in, 1: downstream accept.
- stat_pkts, out, 32: packets passed.
- stat_drops, out, 32: packets dropped on channel mismatch.
- stat_errs, out, 32: framing and protocol errors.

Behaviour:
- **Reset (aclr_n low):** the following are all forced to 0 / cleared:
  - in_ready, out_valid and all three stat counters;
  - the FSM, forced to IDLE;
  - FIFO pointers and count;
  - pending.
  - First in_ready may assert in the first cycle after release.
  - Reset mid-packet discards the packet silently, with no counting.
- **Credit rule:**
  - pending is a register holding the previous cycle's in_ready.
  - in_ready = (fifo_count + pending) < DEPTH, using fifo_count before any same-cycle pop (conservative).
  - Every in_valid word therefore has a reserved FIFO slot and is never backpressured.
- **Protocol violation:**
  - in_valid while pending=0 is accepted if the FIFO has space.
  - Otherwise the word is discarded and stat_errs increments.
- **Output FIFO:**
  - First-word-fall-through; out_valid = !empty.
  - Pop on out_valid && out_ready.
  - Push and pop may occur in the same cycle.
  - At most one push per cycle.
- **FSM states:**
  - IDLE, in_valid:
    - sop && match && eop: push the word; stat_pkts++; stay IDLE.
    - sop && match && !eop: push the word; go PASS.
    - sop && !match: stat_drops++; go DROP, or stay IDLE if eop.
    - !sop: discard; stat_errs++.
  - PASS, in_valid:
    - !sop: push the word; if eop, stat_pkts++ and go IDLE.
    - sop: unexpected start.
      - Push a terminator in place of the word: data 0, channel of the held packet, sop=0, eop=1, err=1.
      - stat_errs++.
      - The new packet is discarded: go DROP, or IDLE if its eop is set.
  - DROP, in_valid:
    - eop: go IDLE.
    - sop: stat_errs++; re-evaluate it as in IDLE.
- **Match:** MATCH_ALL || channel == NODE_ID.
  - The channel is latched at sop.
  - out_channel for continuation words is the latched channel, not in_data[137:130].
- **Counters:** saturate at 32'hFFFF_FFFF and never wrap.
- **Latency:** in_valid to out_valid is 1 cycle when the FIFO is empty.
- **Simultaneous events:** sop+eop on one word is a complete 1-word packet; a pop plus a push at full-minus-one keeps the count unchanged.

Decomposition:
- Package pnode_pkg contains:
  - Field localparams: CH_HI=137, CH_LO=130, SOP_BIT=129, EOP_BIT=128, DATA_W=128, TAP_W=138.
  - typedef enum logic [1:0] {IDLE, PASS, DROP} pnode_state_t.
  - The output word struct {err, channel, sop, eop, data}.
- Sub-module pnode_out_fifo holds:
  - parameters WIDTH and DEPTH;
  - ports push/pop, count, empty/full;
  - asynchronous active-low reset.
  - Instantiate it once.

Test Plan:
- Reset, then hold in_valid=0 → in_ready=1 the cycle after aclr_n rises. With DEPTH=4 and out_ready=0, in_ready deasserts after at most 4 outstanding requests; no word is lost.
- NODE_ID=3, 3-word packet on channel 3 with out_ready=1:
  - out_valid runs for 3 consecutive cycles;
  - sop on word 0, eop on word 2, out_channel=3 on all three;
  - stat_pkts=1.
- 2-word packet on channel 5, then a 1-word packet on channel 3 → only the channel-3 word is emitted, with sop=eop=1; stat_drops=1, stat_pkts=1.
- Channel-3 sop, one data word, then a new sop on channel 3:
  - the third output is the terminator (eop=1, err=1, data=0);
  - stat_errs=1;
  - the following packet's words are not emitted.
- Word with sop=0 in IDLE → no output; stat_errs=1. Then out_ready toggling 1/0 over a 10-word packet keeps order intact with no drops.
- Preload stat_pkts to 32'hFFFF_FFFE (force), send 3 matching packets → stat_pkts holds at 32'hFFFF_FFFF.
